// File: rtl/option_sequencer_if.sv
// rtl/option_sequencer_if.sv - option stream link between option_sequencer and solver
//
// Bundles the solver-facing signals of option_sequencer.
//   master : sequencer side (drives started/option/option_valid/counts, receives verdicts)
//   slave  : solver side
interface option_sequencer_if #(
    parameter int WIDTH     = 16,
    parameter int MAX_LINES = 22,
    parameter int CNT_W     = 7
);
    logic                       started;
    logic [WIDTH-1:0]           option;
    logic                       option_valid;
    logic                       put_back_to_FIFO;
    logic                       resp_valid;
    logic                       solved;
    logic [MAX_LINES*CNT_W-1:0] old_options_amnt;
    logic [CNT_W-1:0]           all_options_remaining;

    modport master (
        output started, option, option_valid, old_options_amnt, all_options_remaining,
        input  put_back_to_FIFO, resp_valid, solved
    );

    modport slave (
        input  started, option, option_valid, old_options_amnt, all_options_remaining,
        output put_back_to_FIFO, resp_valid, solved
    );
endinterface

// File: rtl/option_sequencer.sv
// rtl/option_sequencer.sv - replays line options from a FIFO to the solver pass after pass
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   num_rows/num_cols board size, captured when solving begins
//   load_valid/line/option, load_done   option loading interface
//   load_err          sticky load error (FIFO full or bad line)
//   sol               option stream to/from the solver (option_sequencer_if.master)
//   busy/stalled/done status
module option_sequencer #(
    parameter int WIDTH     = 16,
    parameter int MAX_LINES = 22,
    parameter int CNT_W     = 7,
    parameter int DEPTH     = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          num_rows,
    input  logic [3:0]          num_cols,
    input  logic                load_valid,
    input  logic [4:0]          load_line,
    input  logic [WIDTH-1:0]    load_option,
    input  logic                load_done,
    output logic                load_err,
    option_sequencer_if.master  sol,
    output logic                busy,
    output logic                stalled,
    output logic                done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_IDX, S_OPT, S_WAIT, S_LINE_END, S_PASS_END, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] count_q [MAX_LINES];
    logic [CNT_W-1:0] count_d [MAX_LINES];
    logic [4:0]       line_q, line_d;
    logic [4:0]       lines_q, lines_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] newcnt_q, newcnt_d;
    logic             removed_q, removed_d;
    logic             stalled_q, stalled_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] cur_q, cur_d;

    logic             push, pop;
    logic [WIDTH-1:0] push_data;
    logic             fifo_full, line_in_range, load_ok, load_bad, go, is_last;
    logic [CNT_W-1:0] line_cnt;

    assign fifo_full     = (occ_q == OCC_W'(DEPTH));
    assign line_in_range = (int'(load_line) < MAX_LINES);
    assign load_ok       = (state_q == S_IDLE) && load_valid && line_in_range && !fifo_full;
    assign load_bad      = (state_q == S_IDLE) && load_valid && (!line_in_range || fifo_full);
    // A load in the same cycle wins; load_done is simply seen again next cycle.
    assign go            = (state_q == S_IDLE) && load_done && !load_valid;
    assign is_last       = (line_q == lines_q - 5'd1);
    assign line_cnt      = (int'(line_q) < MAX_LINES) ? count_q[line_q] : '0;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            line_q     <= '0;
            lines_q    <= '0;
            k_q        <= '0;
            newcnt_q   <= '0;
            removed_q  <= 1'b0;
            stalled_q  <= 1'b0;
            load_err_q <= 1'b0;
            cur_q      <= '0;
            for (int i = 0; i < MAX_LINES; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            line_q     <= line_d;
            lines_q    <= lines_d;
            k_q        <= k_d;
            newcnt_q   <= newcnt_d;
            removed_q  <= removed_d;
            stalled_q  <= stalled_d;
            load_err_q <= load_err_d;
            cur_q      <= cur_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage is not reset; occupancy and pointers define its contents.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = (occ_q == '0) ? S_DONE : S_START;
                end
            end
            S_START:    state_d = S_IDX;
            S_IDX:      state_d = (line_cnt == '0) ? S_LINE_END : S_OPT;
            S_OPT:      state_d = S_WAIT;
            S_WAIT: begin
                if (sol.resp_valid) begin
                    state_d = (k_q == CNT_W'(1)) ? S_LINE_END : S_OPT;
                end
            end
            S_LINE_END: begin
                if (sol.solved) begin
                    state_d = S_DONE;
                end else if (is_last) begin
                    state_d = S_PASS_END;
                end else begin
                    state_d = S_IDX;
                end
            end
            S_PASS_END: state_d = (sol.solved || !removed_q) ? S_DONE : S_IDX;
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Datapath next values: FIFO, counters, pass bookkeeping
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        count_d    = count_q;
        line_d     = line_q;
        lines_d    = lines_q;
        k_d        = k_q;
        newcnt_d   = newcnt_q;
        removed_d  = removed_q;
        stalled_d  = stalled_q;
        load_err_d = load_err_q | load_bad;
        cur_d      = cur_q;
        push       = 1'b0;
        pop        = 1'b0;
        push_data  = load_option;

        if (load_ok) begin
            push               = 1'b1;
            count_d[load_line] = count_q[load_line] + 1'b1;
        end

        if (go) begin
            lines_d = {1'b0, num_rows} + {1'b0, num_cols};
            if (occ_q == '0) begin
                stalled_d = 1'b1;
            end
        end

        case (state_q)
            S_START: begin
                line_d    = '0;
                removed_d = 1'b0;
            end
            S_IDX: begin
                k_d = line_cnt;
            end
            S_OPT: begin
                pop   = 1'b1;
                cur_d = mem[rd_ptr_q];
            end
            S_WAIT: begin
                if (sol.resp_valid) begin
                    k_d = k_q - 1'b1;
                    if (sol.put_back_to_FIFO) begin
                        // Re-queue the word that is outstanding, not the new head.
                        push      = 1'b1;
                        push_data = cur_q;
                        newcnt_d  = newcnt_q + 1'b1;
                    end else begin
                        removed_d = 1'b1;
                    end
                end
            end
            S_LINE_END: begin
                if (int'(line_q) < MAX_LINES) begin
                    count_d[line_q] = newcnt_q;
                end
                newcnt_d = '0;
                if (!sol.solved && !is_last) begin
                    line_d = line_q + 5'd1;
                end
            end
            S_PASS_END: begin
                if (!sol.solved) begin
                    if (!removed_q) begin
                        stalled_d = 1'b1;
                    end else begin
                        line_d    = '0;
                        removed_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // Only one option is ever outstanding, so push and pop never share a cycle.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            occ_d    = occ_q + 1'b1;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            occ_d    = occ_q - 1'b1;
        end
    end

    // Outputs
    always_comb begin
        sol.started               = (state_q == S_START);
        sol.option_valid          = (state_q == S_IDX) || (state_q == S_OPT);
        sol.option                = '0;
        if (state_q == S_IDX) begin
            sol.option = WIDTH'(line_q);
        end else if (state_q == S_OPT) begin
            sol.option = mem[rd_ptr_q];
        end
        sol.all_options_remaining = CNT_W'(occ_q);
        sol.old_options_amnt      = '0;
        for (int i = 0; i < MAX_LINES; i++) begin
            sol.old_options_amnt[i*CNT_W +: CNT_W] = count_q[i];
        end
        busy     = (state_q != S_IDLE) && (state_q != S_DONE);
        done     = (state_q == S_DONE);
        stalled  = stalled_q;
        load_err = load_err_q;
    end
endmodule

// File: tb/tb_option_sequencer.sv
// tb/tb_option_sequencer.sv - scoreboard bench for option_sequencer
module tb_option_sequencer;
    localparam int WIDTH     = 16;
    localparam int MAX_LINES = 22;
    localparam int CNT_W     = 7;
    localparam int DEPTH     = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       num_rows, num_cols;
    logic             load_valid, load_done;
    logic [4:0]       load_line;
    logic [WIDTH-1:0] load_option;
    logic             load_err, busy, stalled, done;

    option_sequencer_if #(.WIDTH(WIDTH), .MAX_LINES(MAX_LINES), .CNT_W(CNT_W)) sif ();

    option_sequencer #(.WIDTH(WIDTH), .MAX_LINES(MAX_LINES), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .num_rows    (num_rows),
        .num_cols    (num_cols),
        .load_valid  (load_valid),
        .load_line   (load_line),
        .load_option (load_option),
        .load_done   (load_done),
        .load_err    (load_err),
        .sol         (sif),
        .busy        (busy),
        .stalled     (stalled),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct { int line; int word; } opt_t;
    typedef struct { int word; bit is_idx; bit pb; bit sol; } exp_t;

    opt_t pool[$];
    exp_t sb[$];
    int   pb_plan[$];
    int   exp_cnt[MAX_LINES];
    int   n_checks = 0;
    int   n_errors = 0;

    int l3_line[12] = '{0, 0, 1, 1, 1, 2, 3, 4, 4, 5, 5, 5};
    int l3_word[12] = '{6, 3, 4, 2, 1, 5, 5, 6, 3, 4, 2, 1};

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        load_valid = 1'b0; load_done = 1'b0; load_line = '0; load_option = '0;
        sif.resp_valid = 1'b0; sif.put_back_to_FIFO = 1'b0; sif.solved = 1'b0;
        sb.delete(); pool.delete();
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_one(input int line, input int word);
        load_valid = 1'b1; load_line = 5'(line); load_option = 16'(word);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Loads the 3x3 board; the last load coincides with load_done, which must be deferred.
    task automatic load_3x3();
        num_rows = 4'd3; num_cols = 4'd3;
        for (int i = 0; i < 12; i++) begin
            if (i == 11) load_done = 1'b1;
            load_one(l3_line[i], l3_word[i]);
            pool.push_back('{line: l3_line[i], word: l3_word[i]});
            exp_cnt[l3_line[i]]++;
        end
        chk("done_deferred_busy", int'(busy), 0);
        @(negedge clk);
        load_done = 1'b0;
        chk("started_pulse", int'(sif.started), 1);
        chk("remaining_before_pop", int'(sif.all_options_remaining), 12);
        chk("busy_start", int'(busy), 1);
    endtask

    // Expected stream for one pass; lines past stop_line are never visited.
    task automatic push_pass(input int n_lines, input int stop_line, input int sol_pos);
        opt_t keep[$];
        opt_t rest[$];
        int   cnt;
        for (int l = 0; l < n_lines; l++) begin
            if (l <= stop_line) begin
                sb.push_back('{word: l, is_idx: 1'b1, pb: 1'b0, sol: 1'b0});
                cnt = 0;
                for (int i = 0; i < pool.size(); i++) begin
                    if (pool[i].line == l) begin
                        sb.push_back('{word: pool[i].word, is_idx: 1'b0,
                                       pb: pb_plan[i] != 0, sol: i == sol_pos});
                        if (pb_plan[i] != 0) begin
                            keep.push_back(pool[i]);
                            cnt++;
                        end
                    end
                end
                exp_cnt[l] = cnt;
            end else begin
                for (int i = 0; i < pool.size(); i++)
                    if (pool[i].line == l) rest.push_back(pool[i]);
            end
        end
        pool = keep;
        foreach (rest[i]) pool.push_back(rest[i]);
    endtask

    task automatic run_solver(input int budget);
        exp_t e;
        bit   pending = 1'b0;
        bit   pb = 1'b0;
        bit   sl = 1'b0;
        int   dly = 0;
        int   cyc = 0;
        int   starts = 0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (sif.resp_valid) sif.resp_valid = 1'b0;
            if (pending) begin
                if (dly == 0) begin
                    sif.resp_valid = 1'b1;
                    sif.put_back_to_FIFO = pb;
                    if (sl) sif.solved = 1'b1;
                    pending = 1'b0;
                end else begin
                    dly--;
                end
            end
            if (sif.started) starts++;
            if (sif.option_valid) begin
                if (sb.size() == 0) begin
                    chk("stream_extra", int'(sif.option), -1);
                end else begin
                    e = sb.pop_front();
                    chk(e.is_idx ? "stream_idx" : "stream_opt", int'(sif.option), e.word);
                    if (e.is_idx) begin
                        // Spurious verdict during IDX must be ignored.
                        sif.resp_valid = 1'b1;
                        sif.put_back_to_FIFO = 1'b1;
                    end else begin
                        pending = 1'b1;
                        pb = e.pb;
                        sl = e.sol;
                        dly = $urandom_range(0, 2);
                    end
                end
            end
        end
        sif.resp_valid = 1'b0;
        chk("reached_done", int'(done), 1);
        chk("second_started", starts, 0);
        chk("stream_left", sb.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        for (int l = 0; l < 7; l++)
            chk(tag, int'(sif.old_options_amnt[l*CNT_W +: CNT_W]), exp_cnt[l]);
        chk({tag, "_remaining"}, int'(sif.all_options_remaining), pool.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        int cyc;

        do_reset();
        chk("rst_option_valid", int'(sif.option_valid), 0);
        chk("rst_started", int'(sif.started), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_remaining", int'(sif.all_options_remaining), 0);
        chk("rst_load_err", int'(load_err), 0);

        // Two passes: selective drops, then everything put back -> stall.
        load_3x3();
        pb_plan = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        push_pass(6, 5, -1);
        pb_plan.delete();
        foreach (pool[i]) pb_plan.push_back(1);
        push_pass(6, 5, -1);
        run_solver(2000);
        chk("stall_stalled", int'(stalled), 1);
        chk("stall_busy", int'(busy), 0);
        check_counts("stall_count");
        repeat (5) @(negedge clk);
        chk("after_done_valid", int'(sif.option_valid), 0);
        chk("after_done_done", int'(done), 1);

        // Reset while a verdict is outstanding.
        do_reset();
        load_3x3();
        seen = 0;
        cyc = 0;
        while (seen < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (sif.option_valid) seen++;
        end
        chk("reach_first_opt", seen, 2);
        @(negedge clk);
        chk("wait_busy", int'(busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(sif.option_valid), 0);
        chk("midrst_option", int'(sif.option), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_remaining", int'(sif.all_options_remaining), 0);
        chk("midrst_counts", int'(|sif.old_options_amnt), 0);
        rst = 1'b1;
        sb.delete(); pool.delete();
        foreach (exp_cnt[i]) exp_cnt[i] = 0;

        // Fresh load; solver reports solved on the last col-2 verdict.
        load_3x3();
        pb_plan = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0};
        push_pass(6, 4, 8);
        run_solver(2000);
        chk("solved_stalled", int'(stalled), 0);
        check_counts("solved_count");

        // Nothing loaded: straight to DONE with stall.
        do_reset();
        num_rows = 4'd3; num_cols = 4'd3;
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        chk("empty_done", int'(done), 1);
        chk("empty_stalled", int'(stalled), 1);

        // FIFO overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) load_one(0, i);
        chk("full_no_err", int'(load_err), 0);
        chk("full_remaining", int'(sif.all_options_remaining), DEPTH);
        load_one(0, 999);
        chk("overflow_err", int'(load_err), 1);
        chk("overflow_remaining", int'(sif.all_options_remaining), DEPTH);
        chk("overflow_count", int'(sif.old_options_amnt[CNT_W-1:0]), DEPTH);

        // Out-of-range line.
        do_reset();
        chk("badline_pre_err", int'(load_err), 0);
        load_one(22, 1);
        chk("badline_err", int'(load_err), 1);
        chk("badline_remaining", int'(sif.all_options_remaining), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
